// File: rtl/bsg_manycore_pkg.sv
// Manycore link and packet definitions shared by the host bridge.
// The widths depend on the instance parameters, so they are exposed here as
// constant functions.
// Layout of a link_sif bundle, MSB first:
//   fwd { v, packet, ready_and_rev }
//   rev { v, return_packet, ready_and_rev }
package bsg_manycore_pkg;

    localparam int op_width_lp          = 2;
    localparam int return_type_width_lp = 2;

    typedef enum logic [op_width_lp-1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1,
        e_remote_amo   = 2'd2,
        e_remote_cfg   = 2'd3
    } packet_op_e;

    typedef enum logic [return_type_width_lp-1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } return_packet_type_e;

    // packet = { addr, op, payload, src_y, src_x, y_cord, x_cord }
    function automatic int packet_width(input int addr_w, input int data_w,
                                        input int x_w, input int y_w);
        return addr_w + op_width_lp + data_w + 2 * (x_w + y_w);
    endfunction

    // return packet = { type, data, y_cord, x_cord }
    function automatic int return_packet_width(input int data_w, input int x_w, input int y_w);
        return return_type_width_lp + data_w + x_w + y_w;
    endfunction

    function automatic int link_sif_width(input int addr_w, input int data_w,
                                          input int x_w, input int y_w);
        return packet_width(addr_w, data_w, x_w, y_w)
             + return_packet_width(data_w, x_w, y_w) + 4;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, one write and one read port.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset (clears pointers/count)
//   v_i, data_i, ready_o write side, valid/ready; ready_o depends on FIFO state only
//   v_o, data_o, yumi_i  read side, valid/yumi; data_o is the registered head entry
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr, wptr;
    logic [cnt_w-1:0]   count;
    logic               enq, deq;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    // A full FIFO refuses writes even when the head is leaving this cycle,
    // which keeps ready_o free of any path from yumi_i.
    assign ready_o = (count != cnt_w'(els_p));
    assign v_o     = (count != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= next_ptr(wptr);
            if (deq) rptr <= next_ptr(rptr);
            if (enq && !deq)      count <= count + cnt_w'(1);
            else if (deq && !enq) count <= count - cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_host_bridge.sv
// Host-side endpoint on the manycore loader io link. Host requests go out on
// the fwd link under an outstanding-credit limit, returns come back to the
// host, and manycore-originated requests / host replies pass both ways.
// A fence holds back new requests until every outstanding credit returns.
// Ports:
//   clk_i, reset_i                        clock, synchronous active-high reset
//   link_sif_i / link_sif_o               manycore io link bundles
//   host_req_v_i/_data_i/_ready_o         host request in (valid/ready)
//   host_rsp_v_o/_data_o/_yumi_i          return packets to host (valid/yumi)
//   mc_req_v_o/_data_o/_yumi_i            manycore requests to host (valid/yumi)
//   mc_rsp_v_i/_data_i/_ready_o           host replies to manycore (valid/ready)
//   fence_v_i, fence_done_o               fence request / one-cycle completion pulse
//   out_credits_used_o                    outstanding request count
module bsg_manycore_host_bridge
    import bsg_manycore_pkg::*;
#(
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int max_out_credits_p = 16,
    parameter int fifo_els_p        = 2,
    localparam int pw_lp  = packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int rw_lp  = return_packet_width(data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int lsw_lp = link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int cw_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [lsw_lp-1:0] link_sif_i,
    output logic [lsw_lp-1:0] link_sif_o,
    input  logic              host_req_v_i,
    input  logic [pw_lp-1:0]  host_req_data_i,
    output logic              host_req_ready_o,
    output logic              host_rsp_v_o,
    output logic [rw_lp-1:0]  host_rsp_data_o,
    input  logic              host_rsp_yumi_i,
    output logic              mc_req_v_o,
    output logic [pw_lp-1:0]  mc_req_data_o,
    input  logic              mc_req_yumi_i,
    input  logic              mc_rsp_v_i,
    input  logic [rw_lp-1:0]  mc_rsp_data_i,
    output logic              mc_rsp_ready_o,
    input  logic              fence_v_i,
    output logic              fence_done_o,
    output logic [cw_lp-1:0]  out_credits_used_o
);

    typedef struct packed {
        logic             v;
        logic [pw_lp-1:0] data;
        logic             ready_and_rev;
    } fwd_s;

    typedef struct packed {
        logic             v;
        logic [rw_lp-1:0] data;
        logic             ready_and_rev;
    } rev_s;

    typedef struct packed {
        fwd_s fwd;
        rev_s rev;
    } link_s;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_fence = 2'd1;
    localparam logic [1:0] st_done  = 2'd2;

    link_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    logic [1:0]       state;
    logic [cw_lp-1:0] used;
    logic             req_v;
    logic [pw_lp-1:0] req_data;
    logic             req_offer, send;
    logic             rsp_ready, ret;
    logic             mc_req_ready;
    logic             mc_rsp_v;
    logic [rw_lp-1:0] mc_rsp_data;

    // The offer depends only on registered state; the link's ready only
    // decides whether the head actually leaves.
    assign req_offer = req_v && (used < cw_lp'(max_out_credits_p)) && (state != st_fence);
    assign send      = req_offer && link_in.fwd.ready_and_rev;
    assign ret       = link_in.rev.v && rsp_ready;

    assign link_out.fwd.v             = req_offer;
    assign link_out.fwd.data          = req_data;
    assign link_out.fwd.ready_and_rev = mc_req_ready;
    assign link_out.rev.v             = mc_rsp_v;
    assign link_out.rev.data          = mc_rsp_data;
    assign link_out.rev.ready_and_rev = rsp_ready;

    assign fence_done_o       = (state == st_done);
    assign out_credits_used_o = used;

    bsg_fifo_1r1w_small #(.width_p(pw_lp), .els_p(fifo_els_p)) req_fifo (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(host_req_v_i), .data_i(host_req_data_i), .ready_o(host_req_ready_o),
        .v_o(req_v), .data_o(req_data), .yumi_i(send)
    );

    bsg_fifo_1r1w_small #(.width_p(rw_lp), .els_p(fifo_els_p)) rsp_fifo (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(link_in.rev.v), .data_i(link_in.rev.data), .ready_o(rsp_ready),
        .v_o(host_rsp_v_o), .data_o(host_rsp_data_o), .yumi_i(host_rsp_yumi_i)
    );

    bsg_fifo_1r1w_small #(.width_p(pw_lp), .els_p(fifo_els_p)) mc_req_fifo (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(link_in.fwd.v), .data_i(link_in.fwd.data), .ready_o(mc_req_ready),
        .v_o(mc_req_v_o), .data_o(mc_req_data_o), .yumi_i(mc_req_yumi_i)
    );

    bsg_fifo_1r1w_small #(.width_p(rw_lp), .els_p(fifo_els_p)) mc_rsp_fifo (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(mc_rsp_v_i), .data_i(mc_rsp_data_i), .ready_o(mc_rsp_ready_o),
        .v_o(mc_rsp_v), .data_o(mc_rsp_data), .yumi_i(mc_rsp_v && link_in.rev.ready_and_rev)
    );

    // Outstanding-credit counter. A send and a return in the same cycle cancel.
    // A return with nothing outstanding is a protocol violation; the count
    // holds at zero rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            used <= '0;
        end else begin
            assert (!(ret && !send && (used == '0)))
                else $error("host bridge: credit return with no request outstanding");
            if (send && !ret)                      used <= used + cw_lp'(1);
            else if (ret && !send && (used != '0)) used <= used - cw_lp'(1);
        end
    end

    // Fence FSM. No sends happen in FENCE, so draining only waits on returns.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= st_idle;
        end else begin
            case (state)
                st_idle:  if (fence_v_i) state <= st_fence;
                st_fence: if ((used == '0) && !send) state <= st_done;
                st_done:  state <= st_idle;
                default:  state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_host_bridge.sv
module tb_bsg_manycore_host_bridge;

    localparam int AW = 8, DW = 8, XW = 2, YW = 2, MAXC = 4, ELS = 2;
    localparam int PW  = 26;  // 8 + 2 + 8 + 2*(2+2)
    localparam int RW  = 14;  // 2 + 8 + 2 + 2
    localparam int LSW = 44;  // PW + RW + 4
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    logic          in_fwd_v = 0, in_fwd_rdy = 0, in_rev_v = 0, in_rev_rdy = 1;
    logic [PW-1:0] in_fwd_data = '0;
    logic [RW-1:0] in_rev_data = '0;
    logic [LSW-1:0] link_sif_i, link_sif_o;
    assign link_sif_i = {in_fwd_v, in_fwd_data, in_fwd_rdy, in_rev_v, in_rev_data, in_rev_rdy};

    logic          out_fwd_v, out_fwd_rdy, out_rev_v, out_rev_rdy;
    logic [PW-1:0] out_fwd_data;
    logic [RW-1:0] out_rev_data;
    assign out_fwd_v    = link_sif_o[43];
    assign out_fwd_data = link_sif_o[42:17];
    assign out_fwd_rdy  = link_sif_o[16];
    assign out_rev_v    = link_sif_o[15];
    assign out_rev_data = link_sif_o[14:1];
    assign out_rev_rdy  = link_sif_o[0];

    logic          host_req_v = 0, host_req_ready;
    logic [PW-1:0] host_req_data = '0;
    logic          host_rsp_v, host_rsp_yumi = 0;
    logic [RW-1:0] host_rsp_data;
    logic          mc_req_v, mc_req_yumi = 0;
    logic [PW-1:0] mc_req_data;
    logic          mc_rsp_v = 0, mc_rsp_ready;
    logic [RW-1:0] mc_rsp_data = '0;
    logic          fence_v = 0, fence_done;
    logic [CW-1:0] used;

    bsg_manycore_host_bridge #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .max_out_credits_p(MAXC), .fifo_els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .link_sif_i(link_sif_i), .link_sif_o(link_sif_o),
        .host_req_v_i(host_req_v), .host_req_data_i(host_req_data), .host_req_ready_o(host_req_ready),
        .host_rsp_v_o(host_rsp_v), .host_rsp_data_o(host_rsp_data), .host_rsp_yumi_i(host_rsp_yumi),
        .mc_req_v_o(mc_req_v), .mc_req_data_o(mc_req_data), .mc_req_yumi_i(mc_req_yumi),
        .mc_rsp_v_i(mc_rsp_v), .mc_rsp_data_i(mc_rsp_data), .mc_rsp_ready_o(mc_rsp_ready),
        .fence_v_i(fence_v), .fence_done_o(fence_done), .out_credits_used_o(used)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       req_v, fwd_rdy, ret_v, rsp_yumi;
        logic [2:0] e_used;
        logic       e_fwd_v, e_req_rdy, e_rsp_v, e_rev_rdy;
        int         e_head, e_rsp_head;
    } vec_t;

    function automatic vec_t mk(input int rv, input int fr, input int tv, input int ry,
                                input int eu, input int efv, input int err, input int ersp,
                                input int erev, input int eh, input int erh);
        vec_t v;
        v.req_v = rv[0]; v.fwd_rdy = fr[0]; v.ret_v = tv[0]; v.rsp_yumi = ry[0];
        v.e_used = eu[2:0]; v.e_fwd_v = efv[0]; v.e_req_rdy = err[0];
        v.e_rsp_v = ersp[0]; v.e_rev_rdy = erev[0];
        v.e_head = eh; v.e_rsp_head = erh;
        return v;
    endfunction

    function automatic logic [PW-1:0] reqd(input int i);
        return PW'(i * 7 + 100);
    endfunction

    function automatic logic [RW-1:0] retd(input int i);
        return RW'(i * 3 + 1);
    endfunction

    vec_t tbl[14];
    int   acc, sends, falls;
    logic prev_rdy;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          req fwd ret yumi | used fwd_v req_rdy rsp_v rev_rdy | head rsp_head
        tbl[0]  = mk(1, 1, 0, 0,   0, 1, 1, 0, 1,   0, -1);
        tbl[1]  = mk(0, 1, 0, 0,   1, 0, 1, 0, 1,  -1, -1);
        tbl[2]  = mk(0, 0, 1, 0,   0, 0, 1, 1, 1,  -1,  2);
        tbl[3]  = mk(0, 0, 0, 1,   0, 0, 1, 0, 1,  -1, -1);
        tbl[4]  = mk(1, 0, 0, 0,   0, 1, 1, 0, 1,   4, -1);
        tbl[5]  = mk(1, 0, 0, 0,   0, 1, 0, 0, 1,   4, -1);
        tbl[6]  = mk(0, 1, 0, 0,   1, 1, 1, 0, 1,   5, -1);
        tbl[7]  = mk(1, 1, 0, 0,   2, 1, 1, 0, 1,   7, -1);
        tbl[8]  = mk(0, 1, 1, 0,   2, 0, 1, 1, 1,  -1,  8);
        tbl[9]  = mk(0, 0, 1, 1,   1, 0, 1, 1, 1,  -1,  9);
        tbl[10] = mk(0, 0, 1, 0,   0, 0, 1, 1, 0,  -1,  9);
        tbl[11] = mk(0, 0, 1, 0,   0, 0, 1, 1, 0,  -1,  9);
        tbl[12] = mk(0, 0, 0, 1,   0, 0, 1, 1, 1,  -1, 10);
        tbl[13] = mk(0, 0, 0, 1,   0, 0, 1, 0, 1,  -1, -1);

        // reset state
        step();
        step();
        chk("rst_used", 32'(used), 0);
        chk("rst_fwd_v", 32'(out_fwd_v), 0);
        chk("rst_rev_v", 32'(out_rev_v), 0);
        chk("rst_host_rsp_v", 32'(host_rsp_v), 0);
        chk("rst_mc_req_v", 32'(mc_req_v), 0);
        chk("rst_fence_done", 32'(fence_done), 0);
        reset_i = 1'b0;
        step();
        chk("rst_req_ready", 32'(host_req_ready), 1);
        chk("rst_mc_rsp_ready", 32'(mc_rsp_ready), 1);

        // table-driven request/return traffic
        for (int i = 0; i < 14; i++) begin
            host_req_v    = tbl[i].req_v;
            host_req_data = reqd(i);
            in_fwd_rdy    = tbl[i].fwd_rdy;
            in_rev_v      = tbl[i].ret_v;
            in_rev_data   = retd(i);
            host_rsp_yumi = tbl[i].rsp_yumi;
            step();
            chk($sformatf("v%0d_used", i), 32'(used), 32'(tbl[i].e_used));
            chk($sformatf("v%0d_fwd_v", i), 32'(out_fwd_v), 32'(tbl[i].e_fwd_v));
            chk($sformatf("v%0d_req_ready", i), 32'(host_req_ready), 32'(tbl[i].e_req_rdy));
            chk($sformatf("v%0d_rsp_v", i), 32'(host_rsp_v), 32'(tbl[i].e_rsp_v));
            chk($sformatf("v%0d_rev_ready", i), 32'(out_rev_rdy), 32'(tbl[i].e_rev_rdy));
            if (tbl[i].e_head >= 0)
                chk($sformatf("v%0d_fwd_data", i), 32'(out_fwd_data), 32'(reqd(tbl[i].e_head)));
            if (tbl[i].e_rsp_head >= 0)
                chk($sformatf("v%0d_rsp_data", i), 32'(host_rsp_data), 32'(retd(tbl[i].e_rsp_head)));
        end
        host_req_v = 0; in_fwd_rdy = 0; in_rev_v = 0; host_rsp_yumi = 0;

        // credit limit: host streams 8 requests, nothing returns
        acc = 0; sends = 0; falls = 0; prev_rdy = host_req_ready;
        in_fwd_rdy = 1;
        for (int c = 0; c < 20; c++) begin
            host_req_v    = (acc < 8);
            host_req_data = PW'(200 + acc);
            if (out_fwd_v && in_fwd_rdy) begin
                chk($sformatf("stream_send%0d_data", sends), 32'(out_fwd_data), 32'(200 + sends));
                sends++;
            end
            if (host_req_v && host_req_ready) acc++;
            step();
            if (prev_rdy && !host_req_ready) falls++;
            prev_rdy = host_req_ready;
        end
        host_req_v = 0;
        chk("stream_sends", 32'(sends), 4);
        chk("stream_accepted", 32'(acc), 6);
        chk("stream_used", 32'(used), 4);
        chk("stream_req_ready", 32'(host_req_ready), 0);
        chk("stream_ready_falls", 32'(falls), 1);
        chk("stream_fwd_v", 32'(out_fwd_v), 0);

        // fence with three outstanding
        in_fwd_rdy = 0; in_rev_v = 1; in_rev_data = RW'(14'h55);
        step();
        chk("fence_pre_used", 32'(used), 3);
        chk("fence_pre_fwd_v", 32'(out_fwd_v), 1);
        in_rev_v = 0; fence_v = 1; host_rsp_yumi = 1;
        step();
        fence_v = 0;
        chk("fence_entry_fwd_v", 32'(out_fwd_v), 0);
        chk("fence_entry_used", 32'(used), 3);
        in_fwd_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            in_rev_v = 1; host_rsp_yumi = host_rsp_v;
            step();
            chk($sformatf("fence_ret%0d_fwd_v", k), 32'(out_fwd_v), 0);
            chk($sformatf("fence_ret%0d_done", k), 32'(fence_done), 0);
            chk($sformatf("fence_ret%0d_used", k), 32'(used), 32'(2 - k));
        end
        in_rev_v = 0; host_rsp_yumi = host_rsp_v; in_fwd_rdy = 0;
        step();
        chk("fence_done_pulse", 32'(fence_done), 1);
        chk("fence_done_used", 32'(used), 0);
        chk("fence_done_fwd_v", 32'(out_fwd_v), 1);
        host_rsp_yumi = 0;
        step();
        chk("fence_done_clear", 32'(fence_done), 0);

        // manycore requests with host stalled, then host replies
        in_fwd_v = 1; in_fwd_data = PW'(26'h1111);
        step();
        chk("mc_req_v", 32'(mc_req_v), 1);
        chk("mc_req_data0", 32'(mc_req_data), 32'h1111);
        chk("mc_fwd_ready_open", 32'(out_fwd_rdy), 1);
        in_fwd_data = PW'(26'h2222);
        step();
        chk("mc_fwd_ready_full", 32'(out_fwd_rdy), 0);
        in_fwd_data = PW'(26'h3333);
        step();
        chk("mc_req_hold_head", 32'(mc_req_data), 32'h1111);
        in_fwd_v = 0; mc_req_yumi = 1;
        step();
        chk("mc_req_data1", 32'(mc_req_data), 32'h2222);
        chk("mc_fwd_ready_reopen", 32'(out_fwd_rdy), 1);
        step();
        chk("mc_req_drained", 32'(mc_req_v), 0);
        mc_req_yumi = 0;
        mc_rsp_v = 1; mc_rsp_data = RW'(14'h0abc); in_rev_rdy = 0;
        step();
        chk("mc_rsp_rev_v", 32'(out_rev_v), 1);
        chk("mc_rsp_rev_data0", 32'(out_rev_data), 32'h0abc);
        chk("mc_rsp_ready_open", 32'(mc_rsp_ready), 1);
        mc_rsp_data = RW'(14'h0def);
        step();
        chk("mc_rsp_ready_full", 32'(mc_rsp_ready), 0);
        chk("mc_rsp_rev_hold", 32'(out_rev_data), 32'h0abc);
        mc_rsp_v = 0; in_rev_rdy = 1;
        step();
        chk("mc_rsp_rev_data1", 32'(out_rev_data), 32'h0def);
        chk("mc_rsp_ready_reopen", 32'(mc_rsp_ready), 1);
        step();
        chk("mc_rsp_drained", 32'(out_rev_v), 0);

        // build used=3 with full FIFOs, then reset mid-operation
        host_req_v = 1; host_req_data = PW'(26'h777); in_fwd_rdy = 1;
        in_fwd_v = 1; in_fwd_data = PW'(26'h444);
        mc_rsp_v = 1; mc_rsp_data = RW'(14'h123); in_rev_rdy = 0;
        step(); step(); step();
        in_fwd_rdy = 0;
        step();
        chk("prerst_used", 32'(used), 3);
        chk("prerst_req_ready", 32'(host_req_ready), 0);
        chk("prerst_mc_fwd_ready", 32'(out_fwd_rdy), 0);
        chk("prerst_mc_rsp_ready", 32'(mc_rsp_ready), 0);
        host_req_v = 0; in_fwd_v = 0; mc_rsp_v = 0; in_rev_rdy = 1;
        reset_i = 1;
        step();
        chk("midrst_used", 32'(used), 0);
        chk("midrst_fwd_v", 32'(out_fwd_v), 0);
        chk("midrst_rev_v", 32'(out_rev_v), 0);
        chk("midrst_mc_req_v", 32'(mc_req_v), 0);
        chk("midrst_host_rsp_v", 32'(host_rsp_v), 0);
        chk("midrst_fence_done", 32'(fence_done), 0);
        reset_i = 0;
        step();
        chk("postrst_req_ready", 32'(host_req_ready), 1);
        chk("postrst_mc_rsp_ready", 32'(mc_rsp_ready), 1);
        chk("postrst_mc_fwd_ready", 32'(out_fwd_rdy), 1);

        // fence with nothing outstanding: FENCE one cycle, DONE the next
        fence_v = 1;
        step();
        fence_v = 0;
        chk("fence0_first", 32'(fence_done), 0);
        step();
        chk("fence0_done", 32'(fence_done), 1);
        step();
        chk("fence0_clear", 32'(fence_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
